// File: rtl/tile_arb_pkg.sv
// rtl/tile_arb_pkg.sv - shared types and sizes for the tile RAM arbiter
package tile_arb_pkg;

    localparam int TILE_ADDR_W = 10;
    localparam int TILE_DATA_W = 8;
    localparam int H_TOTAL_DEF = 800;
    localparam int V_TOTAL_DEF = 525;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_INIT,
        GNT_VIDEO,
        GNT_CPU,
        GNT_GL
    } grant_e;

    typedef enum logic {
        ST_RUN,
        ST_INIT
    } arb_state_e;

endpackage

// File: rtl/video_fetch_addr.sv
// rtl/video_fetch_addr.sv - video slot detect and next-cell prefetch address
module video_fetch_addr
    import tile_arb_pkg::*;
#(
    parameter int         H_TOTAL    = H_TOTAL_DEF,
    parameter int         V_TOTAL    = V_TOTAL_DEF,
    parameter logic [3:0] VIDEO_SLOT = 4'hE
) (
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    output logic                   slot,
    output logic [TILE_ADDR_W-1:0] addr
);

    logic [4:0] row;
    logic [4:0] col;
    logic [4:0] next_line_row;

    assign slot = (hpos[3:0] == VIDEO_SLOT);

    // The last slot of a line prefetches column 0 of the following line (or frame top).
    always_comb begin
        next_line_row = (vpos == 10'(V_TOTAL - 1)) ? 5'd0 : 5'((vpos + 10'd1) >> 4);
        if (hpos == 10'(H_TOTAL - 2)) begin
            row = next_line_row;
            col = 5'd0;
        end else begin
            row = vpos[8:4];
            col = hpos[8:4] + 5'd1;
        end
    end

    assign addr = {row, col};

endmodule

// File: rtl/tile_ram_arbiter.sv
// rtl/tile_ram_arbiter.sv - shares the single-port tile RAM between loader, video, CPU and game logic
module tile_ram_arbiter
    import tile_arb_pkg::*;
#(
    parameter int         H_TOTAL    = H_TOTAL_DEF,
    parameter int         V_TOTAL    = V_TOTAL_DEF,
    parameter logic [3:0] VIDEO_SLOT = 4'hE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    input  logic                   init_active,
    input  logic [TILE_ADDR_W-1:0] init_addr,
    input  logic [TILE_DATA_W-1:0] init_wdata,
    input  logic                   init_we,
    output logic [TILE_DATA_W-1:0] video_data,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [TILE_ADDR_W-1:0] cpu_addr,
    input  logic [TILE_DATA_W-1:0] cpu_wdata,
    output logic                   cpu_ack,
    output logic [TILE_DATA_W-1:0] cpu_rdata,
    input  logic                   gl_req,
    input  logic                   gl_we,
    input  logic [TILE_ADDR_W-1:0] gl_addr,
    input  logic [TILE_DATA_W-1:0] gl_wdata,
    output logic                   gl_ack,
    output logic [TILE_DATA_W-1:0] gl_rdata,
    output logic [TILE_ADDR_W-1:0] ram_addr,
    output logic [TILE_DATA_W-1:0] ram_wdata,
    output logic                   ram_we,
    input  logic [TILE_DATA_W-1:0] ram_rdata
);

    grant_e                 grant;
    arb_state_e             state;
    logic                   video_slot;
    logic [TILE_ADDR_W-1:0] video_addr;
    logic                   cpu_elig;
    logic                   gl_elig;
    logic                   rr_gl_next;
    logic                   cpu_rd_pend;
    logic                   gl_rd_pend;
    logic                   video_pend;
    logic [TILE_DATA_W-1:0] cpu_hold;
    logic [TILE_DATA_W-1:0] gl_hold;

    video_fetch_addr #(
        .H_TOTAL    (H_TOTAL),
        .V_TOTAL    (V_TOTAL),
        .VIDEO_SLOT (VIDEO_SLOT)
    ) u_video_fetch_addr (
        .hpos (hpos),
        .vpos (vpos),
        .slot (video_slot),
        .addr (video_addr)
    );

    // A port sitting in its ack cycle is masked so a still-high req is not served twice.
    assign cpu_elig = cpu_req && !cpu_ack;
    assign gl_elig  = gl_req && !gl_ack;

    always_comb begin
        grant = GNT_NONE;
        if (!reset)
            grant = GNT_NONE;
        else if (init_active)
            grant = GNT_INIT;
        else if (video_slot)
            grant = GNT_VIDEO;
        else if (cpu_elig && gl_elig)
            grant = rr_gl_next ? GNT_GL : GNT_CPU;
        else if (cpu_elig)
            grant = GNT_CPU;
        else if (gl_elig)
            grant = GNT_GL;
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (grant)
            GNT_INIT: begin
                ram_addr  = init_addr;
                ram_wdata = init_wdata;
                ram_we    = init_we;
            end
            GNT_VIDEO: ram_addr = video_addr;
            GNT_CPU: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_we;
            end
            GNT_GL: begin
                ram_addr  = gl_addr;
                ram_wdata = gl_wdata;
                ram_we    = gl_we;
            end
            default: ;
        endcase
    end

    // Read data arrives from the RAM in the ack cycle; pass it through then, hold it afterwards.
    assign cpu_rdata = cpu_rd_pend ? ram_rdata : cpu_hold;
    assign gl_rdata  = gl_rd_pend ? ram_rdata : gl_hold;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_RUN;
            cpu_ack     <= 1'b0;
            gl_ack      <= 1'b0;
            cpu_rd_pend <= 1'b0;
            gl_rd_pend  <= 1'b0;
            video_pend  <= 1'b0;
            cpu_hold    <= '0;
            gl_hold     <= '0;
            video_data  <= '0;
            rr_gl_next  <= 1'b0;
        end else begin
            cpu_ack     <= (grant == GNT_CPU);
            gl_ack      <= (grant == GNT_GL);
            cpu_rd_pend <= (grant == GNT_CPU) && !cpu_we;
            gl_rd_pend  <= (grant == GNT_GL) && !gl_we;
            video_pend  <= (grant == GNT_VIDEO);

            if (cpu_rd_pend)
                cpu_hold <= ram_rdata;
            if (gl_rd_pend)
                gl_hold <= ram_rdata;

            if (state == ST_INIT || init_active)
                video_data <= '0;
            else if (video_pend)
                video_data <= ram_rdata;

            if (grant == GNT_CPU)
                rr_gl_next <= 1'b1;
            else if (grant == GNT_GL)
                rr_gl_next <= 1'b0;

            case (state)
                ST_RUN:  if (init_active) state <= ST_INIT;
                ST_INIT: if (!init_active && !cpu_ack && !gl_ack) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// tb/tb_tile_ram_arbiter.sv - directed self-checking bench for tile_ram_arbiter
module tb_tile_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       init_active, init_we;
    logic [9:0] init_addr;
    logic [7:0] init_wdata;
    logic [7:0] video_data;
    logic       cpu_req, cpu_we, cpu_ack;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       gl_req, gl_we, gl_ack;
    logic [9:0] gl_addr;
    logic [7:0] gl_wdata, gl_rdata;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       ram_we;

    logic       bd_we;
    logic [9:0] bd_addr;
    logic [7:0] bd_data;
    logic [7:0] mem [1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tile_ram_arbiter #(
        .H_TOTAL    (800),
        .V_TOTAL    (525),
        .VIDEO_SLOT (4'hE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hpos        (hpos),
        .vpos        (vpos),
        .init_active (init_active),
        .init_addr   (init_addr),
        .init_wdata  (init_wdata),
        .init_we     (init_we),
        .video_data  (video_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .gl_req      (gl_req),
        .gl_we       (gl_we),
        .gl_addr     (gl_addr),
        .gl_wdata    (gl_wdata),
        .gl_ack      (gl_ack),
        .gl_rdata    (gl_rdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata)
    );

    // Single-port sync-read tile RAM with a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       init;
        logic [9:0] iaddr;
        logic       iwe;
        logic [9:0] exp_addr;
        logic       exp_we;
    } addr_vec_t;

    typedef struct {
        logic [9:0] hpos;
        logic       exp_cpu_ack;
        logic       exp_gl_ack;
    } rr_vec_t;

    addr_vec_t av [8];
    rr_vec_t   rv [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    initial begin
        av[0] = '{10'h05E, 10'd48,  1'b0, 10'h000, 1'b0, 10'h066, 1'b0};
        av[1] = '{10'd798, 10'd524, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0};
        av[2] = '{10'd798, 10'd15,  1'b0, 10'h000, 1'b0, 10'h020, 1'b0};
        av[3] = '{10'h1FE, 10'd48,  1'b0, 10'h000, 1'b0, 10'h060, 1'b0};
        av[4] = '{10'h00E, 10'd0,   1'b0, 10'h000, 1'b0, 10'h001, 1'b0};
        av[5] = '{10'h005, 10'd100, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0};
        av[6] = '{10'h30E, 10'd300, 1'b0, 10'h000, 1'b0, 10'h251, 1'b0};
        av[7] = '{10'h05E, 10'd48,  1'b1, 10'h3FF, 1'b1, 10'h3FF, 1'b1};

        rv[0] = '{10'h000, 1'b0, 1'b1};
        rv[1] = '{10'h000, 1'b1, 1'b0};
        rv[2] = '{10'h000, 1'b0, 1'b1};
        rv[3] = '{10'h000, 1'b1, 1'b0};
        rv[4] = '{10'h000, 1'b0, 1'b1};
        rv[5] = '{10'h000, 1'b1, 1'b0};
        rv[6] = '{10'h00E, 1'b0, 1'b0};
        rv[7] = '{10'h00F, 1'b0, 1'b1};
        rv[8] = '{10'h000, 1'b1, 1'b0};

        reset = 1'b0; hpos = '0; vpos = '0;
        init_active = 1'b0; init_we = 1'b0; init_addr = '0; init_wdata = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010; cpu_wdata = '0;
        gl_req = 1'b0; gl_we = 1'b0; gl_addr = '0; gl_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        // Reset with cpu_req held high
        bd_write(10'h010, 8'h33);
        bd_write(10'h066, 8'h21);
        tick();
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_gl_ack", gl_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_gl_rdata", gl_rdata, 0);
        chk("rst_video_data", video_data, 0);
        chk("rst_ram_we", ram_we, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_ack", cpu_ack, 1);
        chk("post_rst_rdata", cpu_rdata, 8'h33);
        cpu_req = 1'b0;
        tick();
        chk("post_rst_ack_pulse", cpu_ack, 0);

        // Loader owns the RAM while init_active
        init_active = 1'b1; init_we = 1'b1; init_addr = 10'h3FF; init_wdata = 8'h5A;
        cpu_req = 1'b1; cpu_addr = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("init_ram_we", ram_we, 1);
            chk("init_ram_addr", ram_addr, 10'h3FF);
            chk("init_cpu_ack", cpu_ack, 0);
            tick();
        end
        chk("init_video_zero", video_data, 0);
        init_active = 1'b0; init_we = 1'b0;
        for (int n = 0; n < 6 && !cpu_ack; n++)
            tick();
        chk("init_release_ack", cpu_ack, 1);
        chk("init_readback", cpu_rdata, 8'h5A);
        cpu_req = 1'b0;
        tick();

        // Video fetch of cell {row 3, col 6}
        hpos = 10'h05E; vpos = 10'd48;
        #1;
        chk("video_addr", ram_addr, 10'h066);
        tick();
        hpos = 10'h05F;
        tick();
        hpos = 10'h060;
        #1;
        chk("video_data_060", video_data, 8'h21);
        tick();
        hpos = 10'h061;
        #1;
        chk("video_data_061", video_data, 8'h21);

        // Address / grant table
        for (int i = 0; i < 8; i++) begin
            hpos = av[i].hpos; vpos = av[i].vpos;
            init_active = av[i].init; init_addr = av[i].iaddr; init_we = av[i].iwe;
            #1;
            chk($sformatf("vec%0d_ram_addr", i), ram_addr, av[i].exp_addr);
            chk($sformatf("vec%0d_ram_we", i), ram_we, av[i].exp_we);
            tick();
        end
        init_active = 1'b0; init_we = 1'b0; hpos = '0;
        tick();
        tick();

        // CPU and GL contend continuously; last grant before this was CPU
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 10'h066;
        for (int k = 0; k < 9; k++) begin
            hpos = rv[k].hpos;
            tick();
            chk($sformatf("rr%0d_cpu_ack", k), cpu_ack, rv[k].exp_cpu_ack);
            chk($sformatf("rr%0d_gl_ack", k), gl_ack, rv[k].exp_gl_ack);
        end
        chk("rr_cpu_rdata", cpu_rdata, 8'h33);
        chk("rr_gl_rdata", gl_rdata, 8'h21);
        cpu_req = 1'b0; gl_req = 1'b0; hpos = '0;
        tick();
        tick();

        // CPU write then GL read of the same address on consecutive grants
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h1A4; cpu_wdata = 8'h07;
        tick();
        chk("wr_cpu_ack", cpu_ack, 1);
        chk("wr_cpu_rdata_kept", cpu_rdata, 8'h33);
        cpu_req = 1'b0; cpu_we = 1'b0;
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 10'h1A4;
        tick();
        chk("rd_gl_ack", gl_ack, 1);
        chk("rd_gl_rdata", gl_rdata, 8'h07);
        gl_req = 1'b0;
        tick();
        chk("rd_gl_ack_pulse", gl_ack, 0);
        chk("rd_gl_rdata_held", gl_rdata, 8'h07);
        chk("rd_cpu_rdata_held", cpu_rdata, 8'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_ram_arbiter.md
# tile_ram_arbiter

Shares the single-port 1024×8 tile RAM (32×32 cells, sync read, 1-cycle latency) between four requesters: map init loader, video tile fetch, CPU bus bridge and game logic (pellet read/clear at pacman cell). Sits between those requesters and the tile RAM in the game top level. Replaces the ad-hoc `init ? {row,col} : {evalXpos,evalYpos}` address mux with a guaranteed video slot and fair CPU/game-logic arbitration.

## Interface
Parameters:
- `H_TOTAL`, 800, pixels per line (multiple of 16)
- `V_TOTAL`, 525, lines per frame
- `VIDEO_SLOT`, 4'hE, `hpos[3:0]` value that owns the RAM for video

Ports:
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  reset; synchronous, active-low
- `hpos`, `vpos`  in  10 each  beam position from hvsync generator
- `init_active`  in  1  map loader owns RAM
- `init_addr`  in  10; `init_wdata`  in  8; `init_we`  in  1  loader write port
- `video_data`  out  8  tile byte for current cell
- `cpu_req`, `cpu_we`  in  1 each; `cpu_addr`  in  10; `cpu_wdata`  in  8
- `cpu_ack`  out  1; `cpu_rdata`  out  8
- `gl_req`, `gl_we`  in  1 each; `gl_addr`  in  10; `gl_wdata`  in  8
- `gl_ack`  out  1; `gl_rdata`  out  8
- `ram_addr`  out  10; `ram_wdata`  out  8; `ram_we`  out  1; `ram_rdata`  in  8

## Operation
- Grant computed combinationally each cycle, priority: INIT > VIDEO > CPU/GL round-robin > NONE. `ram_addr/ram_wdata/ram_we` driven from grantee same cycle; NONE drives addr 0, we 0.
- INIT: whenever `init_active`=1; passes `init_*` straight through; CPU/GL never granted, `video_data` forced to 0.
- VIDEO: when `hpos[3:0]==VIDEO_SLOT` and not init. Address `{row, col}` prefetches the next cell: col = `hpos[8:4]+1` (5-bit wrap), row = `vpos[8:4]`. Exception: at `hpos==H_TOTAL-2`, col=0 and row = `(vpos==V_TOTAL-1 ? 0 : vpos+1)[8:4]`. Read only.
- CPU/GL: on non-init, non-video cycles among requesters with `req`=1 and not masked. Both requesting: winner is the one not granted last; pointer updates only on a CPU/GL grant; reset pointer favours CPU.
- Handshake: requester holds `req/we/addr/wdata` stable until `ack`. Grant in cycle N → `ack` 1-cycle pulse in N+1, `rdata` = `ram_rdata` registered, valid in N+1 and held until next ack to that port. Writes ack identically; `rdata` then undefined-but-stable (keeps last value). Requester in its ack cycle is masked from grant (no double service if `req` still high); it must drop or re-present `req` from N+2.
- States: RUN (normal) and INIT (`init_active`); INIT→RUN on `init_active` fall with no pending acks; any grant in flight when INIT rises still acks normally in the next cycle.

## Timing
- Reset (`reset`=0 at edge): `cpu_ack`=`gl_ack`=0, `cpu_rdata`=`gl_rdata`=0, `video_data`=0, rr pointer=CPU, in-flight acks discarded; combinational outputs follow (`ram_we`=0 while reset low).
- Video: address at `hpos==…E`, RAM data at `…F`, `video_data` registered at end of `…F`, valid from `hpos[3:0]==0` of the target cell for all 16 pixels.
- Max CPU/GL latency: req to ack ≤ 4 cycles when both contend (one video slot + one lost round).
- Simultaneous: video slot with both CPU and GL pending → neither granted, pointer unchanged.
- Write-then-read same address by different requesters on consecutive grants returns new data.

## Structure
- Package `tile_arb_pkg`: grant enum {GNT_NONE, GNT_INIT, GNT_VIDEO, GNT_CPU, GNT_GL}, `H_TOTAL`/`V_TOTAL` defaults, `TILE_ADDR_W=10`, `TILE_DATA_W=8`.
- Sub-module `video_fetch_addr`: slot detect + prefetch address incl. line/frame wrap; arbiter core holds grant, pipeline regs, rr pointer.

## Test plan
- Reset with `cpu_req`=1 held: all registered outputs 0; first ack 1 cycle after reset releases on a non-video cycle.
- `init_active`=1, `init_we`=1, addr 0x3FF data 0x5A, `cpu_req`=1: `ram_we`=1 addr 0x3FF every cycle, `cpu_ack` stays 0 until init drops.
- RAM preloaded 0x21 at {row 3,col 6}: vpos=48, hpos=0x05E → `ram_addr`=0x066, `video_data`=0x21 from hpos=0x060.
- Line wrap: vpos=524, hpos=798 → `ram_addr`=0x000; vpos=15, hpos=798 → `ram_addr`=0x020.
- CPU and GL both hold req continuously on non-video cycles: grants alternate CPU, GL, CPU…; each ack single-cycle; no back-to-back ack to same port.
- CPU writes 0x07 to 0x1A4, GL then reads 0x1A4 → `gl_rdata`=0x07 with `gl_ack`.
